// File: rtl/mvm_dot_engine_if.sv
// Datapath bus of the dot-product engine: input fifo pop side, weight store
// read port and output fifo push side.
//   master : engine side (pops input, drives weight address, pushes results)
//   slave  : fifo / weight-store side
interface mvm_dot_engine_if #(
  parameter int DATAW = 8,
  parameter int ACCW  = 32,
  parameter int ADDRW = 9
);
  logic             in_empty;
  logic             in_pop;
  logic [DATAW-1:0] in_data;
  logic [ADDRW-1:0] w_raddr;
  logic [DATAW-1:0] w_rdata;
  logic             out_almost_full;
  logic             out_push;
  logic [ACCW-1:0]  out_data;

  modport master (
    input  in_empty, in_data, w_rdata, out_almost_full,
    output in_pop, w_raddr, out_push, out_data
  );

  modport slave (
    output in_empty, in_data, w_rdata, out_almost_full,
    input  in_pop, w_raddr, out_push, out_data
  );
endinterface

// File: rtl/mvm_dot_engine.sv
// Streaming dot-product engine: pops signed vector elements, multiplies each
// by the matching weight (2-cycle read latency) and pushes one accumulated
// result per vector. start/busy/done bracket a batch of num_vec vectors.
//   clk, rst  : clock, synchronous active-high reset
//   start     : batch start pulse (accepted in IDLE only)
//   num_vec   : vectors in the batch, sampled on accepted start
//   busy/done : busy outside IDLE, done pulses for one cycle at completion
//   bus       : input fifo / weight store / output fifo (master side)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | popping elements and issuing weight reads
// DRAIN | all elements popped, pipeline emptying
// DONE  | one-cycle completion pulse
module mvm_dot_engine #(
  parameter int DATAW = 8,
  parameter int ACCW  = 32,
  parameter int VLEN  = 64,
  parameter int NROWS = 8,
  parameter int ADDRW = $clog2(VLEN*NROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           num_vec,
  output logic                  busy,
  output logic                  done,
  mvm_dot_engine_if.master      bus
);
  localparam int ROWW = (NROWS > 1) ? $clog2(NROWS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                   state_q, state_d;
  logic [ADDRW-1:0]         col_q, col_d, base_q, base_d;
  logic [ROWW-1:0]          row_q, row_d;
  logic [15:0]              vec_cnt_q, vec_cnt_d;

  logic                     s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic signed [DATAW-1:0]  s1_data_q, s1_data_d;
  logic                     s2_vld_q, s2_vld_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic signed [DATAW-1:0]  s2_data_q, s2_data_d;
  logic                     p_vld_q, p_vld_d, p_first_q, p_first_d, p_last_q, p_last_d;
  logic [ACCW-1:0]          p_val_q, p_val_d;
  logic [ACCW-1:0]          acc_q, acc_d;
  logic                     out_push_q, out_push_d;
  logic [ACCW-1:0]          out_data_q, out_data_d;

  logic                     pop;
  logic                     col_last;
  logic signed [2*DATAW-1:0] prod;

  assign pop      = (state_q == RUN) && !bus.in_empty && !bus.out_almost_full;
  assign col_last = (col_q == ADDRW'(VLEN-1));
  // Both operands widened first so the product keeps its full signed range.
  assign prod     = (2*DATAW)'(s2_data_q) * (2*DATAW)'($signed(bus.w_rdata));

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    base_d    = base_q;
    vec_cnt_d = vec_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          col_d     = '0;
          row_d     = '0;
          base_d    = '0;
          vec_cnt_d = num_vec;
          state_d   = (num_vec == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pop) begin
          if (col_last) begin
            col_d     = '0;
            vec_cnt_d = vec_cnt_q - 16'd1;
            if (row_q == ROWW'(NROWS-1)) begin
              row_d  = '0;
              base_d = '0;
            end else begin
              row_d  = row_q + ROWW'(1);
              base_d = base_q + ADDRW'(VLEN);
            end
            if (vec_cnt_q == 16'd1) state_d = DRAIN;
          end else begin
            col_d = col_q + ADDRW'(1);
          end
        end
      end
      DRAIN: begin
        // Empty pipeline here means the final push is on the output this cycle.
        if (!s1_vld_q && !s2_vld_q && !p_vld_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_vld_d   = pop;
    s1_data_d  = bus.in_data;
    s1_first_d = (col_q == '0);
    s1_last_d  = col_last;
    s2_vld_d   = s1_vld_q;
    s2_data_d  = s1_data_q;
    s2_first_d = s1_first_q;
    s2_last_d  = s1_last_q;
    p_vld_d    = s2_vld_q;
    p_val_d    = ACCW'(prod);
    p_first_d  = s2_first_q;
    p_last_d   = s2_last_q;
    acc_d      = acc_q;
    out_push_d = 1'b0;
    out_data_d = out_data_q;
    if (p_vld_q) begin
      acc_d = p_first_q ? p_val_q : acc_q + p_val_q;
      if (p_last_q) begin
        out_push_d = 1'b1;
        out_data_d = acc_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      base_q     <= '0;
      vec_cnt_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_data_q  <= '0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      p_vld_q    <= 1'b0;
      p_val_q    <= '0;
      p_first_q  <= 1'b0;
      p_last_q   <= 1'b0;
      acc_q      <= '0;
      out_push_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      base_q     <= base_d;
      vec_cnt_q  <= vec_cnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_data_q  <= s1_data_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s2_vld_q   <= s2_vld_d;
      s2_data_q  <= s2_data_d;
      s2_first_q <= s2_first_d;
      s2_last_q  <= s2_last_d;
      p_vld_q    <= p_vld_d;
      p_val_q    <= p_val_d;
      p_first_q  <= p_first_d;
      p_last_q   <= p_last_d;
      acc_q      <= acc_d;
      out_push_q <= out_push_d;
      out_data_q <= out_data_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign bus.in_pop   = pop;
  assign bus.w_raddr  = base_q + col_q;
  assign bus.out_push = out_push_q;
  assign bus.out_data = out_data_q;
endmodule

// File: tb/tb_mvm_dot_engine.sv
module tb_mvm_dot_engine;
  localparam int DATAW = 8;
  localparam int ACCW  = 32;
  localparam int VLEN  = 4;
  localparam int NROWS = 2;
  localparam int ADDRW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b1;
  logic [15:0] num_vec = 16'd3;
  logic        busy, done;

  mvm_dot_engine_if #(.DATAW(DATAW), .ACCW(ACCW), .ADDRW(ADDRW)) bus ();

  mvm_dot_engine #(.DATAW(DATAW), .ACCW(ACCW), .VLEN(VLEN), .NROWS(NROWS), .ADDRW(ADDRW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Weight store with 2-cycle read latency
  logic signed [7:0] wmem [0:7];
  logic [2:0] ra1, ra2;
  always @(posedge clk) begin
    ra1 <= bus.w_raddr;
    ra2 <= ra1;
  end
  assign bus.w_rdata = wmem[ra2];

  // Input fifo contents for the current batch
  logic signed [7:0] feed [0:63];
  int feed_len = 4;
  bit stall_en = 0;

  typedef struct { int cyc; int val; } push_t;
  push_t push_q[$];
  int    lit_q[$];

  int n_pass = 0, n_total = 0;
  int pop_idx = 0, cyc = 0;
  bit exp_busy = 0, exp_done = 0, rst_prev = 1;
  int exp_total = 0, pushes_left = 0, batch_pushes = 0, batch_nv = 0;
  int last_out = 0, vec_sum = 0;
  int tmo_cnt = 0, tmo_seen = 0;
  int idx, vec, col, row, v;
  bit exp_push, exp_pop, done_next, busy_next;
  push_t pe;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Model and compare: every cycle, at the falling edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_push = (push_q.size() > 0) && (push_q[0].cyc == cyc);
      check("out_push", int'(bus.out_push), int'(exp_push));
      if (exp_push) begin
        v = push_q[0].val;
        push_q.pop_front();
        last_out = v;
        batch_pushes++;
        if (lit_q.size() > 0) begin
          check("lit_result", $signed(bus.out_data), lit_q[0]);
          lit_q.pop_front();
        end
      end
      check("out_data", $signed(bus.out_data), last_out);
      check("done", int'(done), int'(exp_done));
      check("busy", int'(busy), int'(exp_busy));
      if (rst_prev) check("w_raddr_rst", int'(bus.w_raddr), 0);
      exp_pop = exp_busy && (pop_idx < exp_total) && !bus.in_empty && !bus.out_almost_full;
      check("in_pop", int'(bus.in_pop), int'(exp_pop));
      if (bus.in_pop && pop_idx < 64) begin
        idx = pop_idx;
        vec = idx / VLEN;
        col = idx % VLEN;
        row = vec % NROWS;
        check("w_raddr", int'(bus.w_raddr), row*VLEN + col);
        vec_sum = ((col == 0) ? 0 : vec_sum) + int'(feed[idx]) * int'(wmem[row*VLEN + col]);
        if (col == VLEN-1) begin
          pe.cyc = cyc + 4;
          pe.val = vec_sum;
          push_q.push_back(pe);
        end
        pop_idx++;
      end
      done_next = 0;
      busy_next = exp_busy;
      if (exp_push) begin
        pushes_left--;
        if (pushes_left == 0) done_next = 1;
      end
      if (exp_done) begin
        busy_next = 0;
        check("push_count", batch_pushes, batch_nv);
      end
      if (start && !exp_busy) begin
        pop_idx      = 0;
        exp_total    = int'(num_vec) * VLEN;
        pushes_left  = int'(num_vec);
        batch_nv     = int'(num_vec);
        batch_pushes = 0;
        busy_next    = 1;
        if (num_vec == 16'd0) done_next = 1;
      end
      if (tmo_cnt != tmo_seen) begin
        check("timeout", tmo_cnt, tmo_seen);
        tmo_seen = tmo_cnt;
      end
      if (rst) begin
        push_q.delete();
        busy_next   = 0;
        done_next   = 0;
        pop_idx     = 0;
        exp_total   = 0;
        pushes_left = 0;
        last_out    = 0;
      end
      rst_prev = rst;
      exp_busy = busy_next;
      exp_done = done_next;
      cyc++;
    end
  end

  // Input fifo / output fifo status driver
  initial begin
    bus.in_empty        = 1'b0;
    bus.in_data         = '0;
    bus.out_almost_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.in_empty        = (pop_idx >= feed_len) || (stall_en && $urandom_range(0, 9) < 3);
      bus.in_data         = (pop_idx < feed_len && pop_idx < 64) ? feed[pop_idx] : 8'sd0;
      bus.out_almost_full = stall_en && ($urandom_range(0, 9) < 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int k, input int a, input int b, input int c, input int d);
    feed[k*4+0] = 8'(a);
    feed[k*4+1] = 8'(b);
    feed[k*4+2] = 8'(c);
    feed[k*4+3] = 8'(d);
  endtask

  task automatic set_row(input int r, input int a, input int b, input int c, input int d);
    wmem[r*4+0] = 8'(a);
    wmem[r*4+1] = 8'(b);
    wmem[r*4+2] = 8'(c);
    wmem[r*4+3] = 8'(d);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 500) begin
      tick();
      k++;
    end
    if (!done) tmo_cnt++;
    tick();
    tick();
  endtask

  task automatic go(input int nv);
    num_vec = 16'(nv);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    set_row(0, 1, 2, 3, 4);
    set_row(1, -1, -1, -1, -1);
    set_vec(0, 1, 1, 1, 1);
    set_vec(1, 2, 3, 0, 0);
    set_vec(2, 5, 0, 0, 1);
    // reset held 2 cycles with start and a non-empty fifo
    repeat (2) tick();
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) tick();

    // basic two-vector batch
    feed_len = 8;
    lit_q.push_back(10);
    lit_q.push_back(-5);
    go(2);
    wait_done();

    // row wrap: third vector reuses row 0
    feed_len = 12;
    lit_q.push_back(10);
    lit_q.push_back(-5);
    lit_q.push_back(9);
    go(3);
    wait_done();

    // signed extremes
    set_row(0, -128, -128, -128, -128);
    set_vec(0, -128, -128, -128, -128);
    feed_len = 4;
    lit_q.push_back(65536);
    go(1);
    wait_done();
    set_vec(0, 127, 127, 127, 127);
    lit_q.push_back(-65024);
    go(1);
    wait_done();
    set_row(0, 1, 2, 3, 4);
    set_vec(0, 1, 1, 1, 1);

    // random empty gaps and almost-full pulses
    feed_len = 12;
    stall_en = 1;
    lit_q.push_back(10);
    lit_q.push_back(-5);
    lit_q.push_back(9);
    go(3);
    wait_done();
    stall_en = 0;

    // zero-vector batch
    go(0);
    wait_done();

    // start while busy is ignored
    feed_len = 8;
    lit_q.push_back(10);
    lit_q.push_back(-5);
    go(2);
    repeat (3) tick();
    num_vec = 16'd5;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_done();

    // reset in the middle of the first vector
    go(2);
    for (int k = 0; k < 100 && pop_idx < 2; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();

    // fresh batch after reset starts at row 0
    feed_len = 12;
    lit_q.push_back(10);
    lit_q.push_back(-5);
    lit_q.push_back(9);
    go(3);
    wait_done();

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
